// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the instruction writer: format tags,
// base opcodes, the canonical NOP and the loader state encoding.
package rv32i_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } inst_fmt_e;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    // addi x0,x0,0 -- substituted for beats with an unknown format
    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

endpackage

// File: rtl/instruction_field_pack.sv
// Combinational packer: decoded RV32I fields plus a format tag become one
// 32-bit instruction word. Unknown formats yield a NOP and raise illegal_o.
module instruction_field_pack
    import rv32i_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    logic [31:0] word_s;
    logic        illegal_s;

    // Select the bit layout for the requested format; immediate bits outside it are dropped
    always_comb begin
        word_s    = NOP_INST;
        illegal_s = 1'b0;
        case (fmt_i)
            FMT_R: word_s = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_I: word_s = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            FMT_S: word_s = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            FMT_B: word_s = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                             imm_i[4:1], imm_i[11], opcode_i};
            FMT_U: word_s = {imm_i[31:12], rd_i, opcode_i};
            FMT_J: word_s = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            default: begin
                word_s    = NOP_INST;
                illegal_s = 1'b1;
            end
        endcase
    end

    assign word_o    = word_s;
    assign illegal_o = illegal_s;

endmodule

// File: rtl/instruction_encode.sv
// Instruction writer: packs field beats into RV32I words, buffers them in a
// 2-entry FIFO and streams them to consecutive instruction-memory addresses.
module instruction_encode
    import rv32i_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32'd10,
    parameter int unsigned BASE_ADDR = 32'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt_i,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    input  logic              last_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W:0]   count_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] BASE_W = ADDR_W'(BASE_ADDR);

    enc_state_e        state_r;
    enc_state_e        state_nxt_s;
    logic [31:0]       fifo_r [0:1];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        occ_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W:0]   count_r;
    logic              done_r;
    logic              err_r;
    logic [31:0]       enc_word_s;
    logic              enc_illegal_s;
    logic              push_s;
    logic              pop_s;

    instruction_field_pack u_pack (
        .fmt_i     (fmt_i),
        .opcode_i  (opcode_i),
        .rd_i      (rd_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .funct3_i  (funct3_i),
        .funct7_i  (funct7_i),
        .imm_i     (imm_i),
        .word_o    (enc_word_s),
        .illegal_o (enc_illegal_s)
    );

    // Occupancy is taken before any pop, so a same-cycle write never frees a slot
    assign in_ready = (state_r == ST_LOAD) && (occ_r < 2'd2);

    // Handshake qualification; a start pulse suppresses both push and pop
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (start) begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end else begin
            push_s = in_valid & in_ready;
            pop_s  = (occ_r != 2'd0) & mem_ready_i;
        end
    end

    // Next-state logic; DONE is entered as the final buffered word is written
    always_comb begin
        state_nxt_s = state_r;
        if (start) begin
            state_nxt_s = ST_LOAD;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_IDLE;
                ST_LOAD: begin
                    if (push_s && last_i) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if ((occ_r == 2'd0) || ((occ_r == 2'd1) && pop_s)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                ST_DONE:  state_nxt_s = ST_DONE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register and done flag (done mirrors the state being entered)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Two-entry FIFO storage and pointers; start flushes without touching storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_r[0] <= 32'd0;
            fifo_r[1] <= 32'd0;
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            occ_r     <= 2'd0;
        end else if (start) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            occ_r    <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= enc_word_s;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            occ_r <= occ_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // Write address and word counter advance per completed write and wrap silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r  <= BASE_W;
            count_r <= '0;
        end else if (start) begin
            addr_r  <= BASE_W;
            count_r <= '0;
        end else if (pop_s) begin
            addr_r  <= addr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
            count_r <= count_r + {{ADDR_W{1'b0}}, 1'b1};
        end
    end

    // Sticky illegal-format flag, cleared only by start or reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (start) begin
            err_r <= 1'b0;
        end else if (push_s && enc_illegal_s) begin
            err_r <= 1'b1;
        end
    end

    assign mem_we_o    = (occ_r != 2'd0);
    assign mem_wdata_o = fifo_r[rd_ptr_r];
    assign mem_addr_o  = addr_r;
    assign count_o     = count_r;
    assign done_o      = done_r;
    assign err_o       = err_r;

endmodule

// File: tb/tb_instruction_encode.sv
// Self-checking bench for instruction_encode: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_instruction_encode;

    localparam int unsigned AW = 32'd2;

    logic          clk;
    logic          rst;
    logic          start_s;
    logic          in_valid_s;
    logic          in_ready_s;
    logic [2:0]    fmt_s;
    logic [6:0]    opcode_s;
    logic [4:0]    rd_s;
    logic [4:0]    rs1_s;
    logic [4:0]    rs2_s;
    logic [2:0]    funct3_s;
    logic [6:0]    funct7_s;
    logic [31:0]   imm_s;
    logic          last_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [31:0]   mem_wdata_s;
    logic          mem_ready_s;
    logic [AW:0]   count_s;
    logic          done_s;
    logic          err_s;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: 0 idle, 1 loading, 2 draining, 3 finished
    int          m_state;
    logic [31:0] m_q[$];
    int          m_addr;
    int          m_count;
    bit          m_err;
    bit          accepted;

    instruction_encode #(.ADDR_W(AW), .BASE_ADDR(32'd0)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start_s),
        .in_valid    (in_valid_s),
        .in_ready    (in_ready_s),
        .fmt_i       (fmt_s),
        .opcode_i    (opcode_s),
        .rd_i        (rd_s),
        .rs1_i       (rs1_s),
        .rs2_i       (rs2_s),
        .funct3_i    (funct3_s),
        .funct7_i    (funct7_s),
        .imm_i       (imm_s),
        .last_i      (last_s),
        .mem_we_o    (mem_we_s),
        .mem_addr_o  (mem_addr_s),
        .mem_wdata_o (mem_wdata_s),
        .mem_ready_i (mem_ready_s),
        .count_o     (count_s),
        .done_o      (done_s),
        .err_o       (err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference encoding built from shifts and masks of the field values
    function automatic logic [31:0] ref_word(input logic [2:0] f, input logic [6:0] opc,
                                             input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [31:0] imm,
                                             output bit ill);
        logic [31:0] w;
        logic [31:0] com;
        ill = 1'b0;
        com = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(opc);
        case (f)
            3'd0: w = (32'(f7) << 25) | (32'(rs2) << 20) | com | (32'(rd) << 7);
            3'd1: w = ((imm & 32'hFFF) << 20) | com | (32'(rd) << 7);
            3'd2: w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | com | ((imm & 32'h1F) << 7);
            3'd3: w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
                      (32'(rs2) << 20) | com | (((imm >> 1) & 32'hF) << 8) |
                      (((imm >> 11) & 32'h1) << 7);
            3'd4: w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(opc);
            3'd5: w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                      (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
                      (32'(rd) << 7) | 32'(opc);
            default: begin
                w   = 32'h00000013;
                ill = 1'b1;
            end
        endcase
        return w;
    endfunction

    task automatic set_beat(input logic [2:0] f, input logic [6:0] opc, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm, input logic last);
        fmt_s = f; opcode_s = opc; rd_s = rd; rs1_s = rs1; rs2_s = rs2;
        funct3_s = f3; funct7_s = f7; imm_s = imm; last_s = last;
    endtask

    task automatic rand_beat(input logic last);
        int r;
        r = int'($urandom_range(0, 19));
        set_beat((r < 18) ? 3'(r % 6) : 3'(r - 12), 7'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 3'($urandom), 7'($urandom), $urandom, last);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_q.delete();
        m_addr  = 0;
        m_count = 0;
        m_err   = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, advance the model, return #1 after rise
    task automatic step();
        bit          exp_ready;
        bit          wr;
        bit          ill;
        logic [31:0] w;
        @(negedge clk);
        exp_ready = (m_state == 1) && (m_q.size() < 2);
        chk("in_ready", 32'(in_ready_s), 32'(exp_ready));
        chk("mem_we", 32'(mem_we_s), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("wdata", mem_wdata_s, m_q[0]);
        chk("addr", 32'(mem_addr_s), 32'(m_addr));
        chk("count", 32'(count_s), 32'(m_count));
        chk("done", 32'(done_s), 32'(m_state == 3));
        chk("err", 32'(err_s), 32'(m_err));
        accepted = in_valid_s && exp_ready && !start_s;
        wr       = (m_q.size() != 0) && mem_ready_s && !start_s;
        if (start_s) begin
            m_q.delete();
            m_addr  = 0;
            m_count = 0;
            m_err   = 1'b0;
            m_state = 1;
        end else begin
            if (wr) begin
                void'(m_q.pop_front());
                m_addr  = (m_addr + 1) % 4;
                m_count = (m_count + 1) % 8;
            end
            if (accepted) begin
                w = ref_word(fmt_s, opcode_s, rd_s, rs1_s, rs2_s, funct3_s, funct7_s, imm_s, ill);
                m_q.push_back(w);
                if (ill) m_err = 1'b1;
                if (last_s) m_state = 2;
            end
            if (m_state == 2 && m_q.size() == 0) m_state = 3;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_s = 1'b1;
        step();
        start_s = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_s = 1'b0; in_valid_s = 1'b0; mem_ready_s = 1'b0;
        set_beat(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
        model_reset();
        accepted = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready_s), 32'd0);
        chk("rst_we", 32'(mem_we_s), 32'd0);
        chk("rst_addr", 32'(mem_addr_s), 32'd0);
        chk("rst_wdata", mem_wdata_s, 32'd0);
        chk("rst_count", 32'(count_s), 32'd0);
        chk("rst_done", 32'(done_s), 32'd0);
        chk("rst_err", 32'(err_s), 32'd0);
        rst = 1'b0;
        step();
        step();

        // Directed program: add, addi, beq, jal, then one more word to wrap the address
        pulse_start();
        mem_ready_s = 1'b1;
        in_valid_s  = 1'b1;
        set_beat(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        step();
        chk("add_word", mem_wdata_s, 32'h002081B3);
        chk("add_addr", 32'(mem_addr_s), 32'd0);
        set_beat(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b0);
        step();
        chk("addi_word", mem_wdata_s, 32'hFFF00293);
        chk("addi_addr", 32'(mem_addr_s), 32'd1);
        set_beat(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b0);
        step();
        chk("beq_word", mem_wdata_s, 32'h00208463);
        chk("beq_addr", 32'(mem_addr_s), 32'd2);
        set_beat(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
        step();
        chk("jal_word", mem_wdata_s, 32'h001000EF);
        chk("jal_addr", 32'(mem_addr_s), 32'd3);
        set_beat(3'd4, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0);
        step();
        chk("lui_word", mem_wdata_s, 32'h123453B7);
        chk("wrap_addr", 32'(mem_addr_s), 32'd0);
        in_valid_s = 1'b0;
        repeat (2) step();

        // Back-pressure: only two beats fit while memory stalls
        pulse_start();
        mem_ready_s = 1'b0;
        in_valid_s  = 1'b1;
        rand_beat(1'b0);
        repeat (5) begin
            step();
            if (accepted) rand_beat(1'b0);
        end
        chk("stall_in_ready", 32'(in_ready_s), 32'd0);
        chk("stall_addr", 32'(mem_addr_s), 32'd0);
        mem_ready_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (accepted) in_valid_s = 1'b0;
        end
        repeat (2) step();
        chk("stall_count", 32'(count_s), 32'd3);

        // Illegal format: NOP written, sticky error until the next start
        pulse_start();
        in_valid_s = 1'b1;
        set_beat(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        step();
        chk("nop_word", mem_wdata_s, 32'h00000013);
        rand_beat(1'b0);
        fmt_s = 3'd1;
        step();
        in_valid_s = 1'b0;
        repeat (3) step();
        chk("err_sticky", 32'(err_s), 32'd1);
        pulse_start();
        chk("err_clear", 32'(err_s), 32'd0);

        // last on the third beat while memory stalls: DRAIN, then DONE after the third write
        mem_ready_s = 1'b0;
        in_valid_s  = 1'b1;
        rand_beat(1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            if (accepted) rand_beat(1'b0);
        end
        mem_ready_s = 1'b1;
        step();
        mem_ready_s = 1'b0;
        rand_beat(1'b1);
        step();
        in_valid_s = 1'b0;
        repeat (3) step();
        chk("drain_in_ready", 32'(in_ready_s), 32'd0);
        chk("drain_done", 32'(done_s), 32'd0);
        mem_ready_s = 1'b1;
        repeat (2) step();
        chk("last_done", 32'(done_s), 32'd1);
        chk("last_count", 32'(count_s), 32'd3);

        // Restart mid-load with two words buffered
        pulse_start();
        mem_ready_s = 1'b0;
        in_valid_s  = 1'b1;
        rand_beat(1'b0);
        repeat (3) begin
            step();
            if (accepted) rand_beat(1'b0);
        end
        mem_ready_s = 1'b1;
        pulse_start();
        chk("restart_we", 32'(mem_we_s), 32'd0);
        set_beat(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        step();
        chk("restart_word", mem_wdata_s, 32'h002081B3);
        chk("restart_addr", 32'(mem_addr_s), 32'd0);
        in_valid_s = 1'b0;
        repeat (2) step();

        // Randomized traffic with occasional restarts and one asynchronous reset
        rand_beat(1'b0);
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                rst = 1'b1;
                #1;
                chk("arst_we", 32'(mem_we_s), 32'd0);
                chk("arst_addr", 32'(mem_addr_s), 32'd0);
                chk("arst_count", 32'(count_s), 32'd0);
                chk("arst_done", 32'(done_s), 32'd0);
                #2;
                rst = 1'b0;
                model_reset();
            end
            if (m_state == 0 || m_state == 3) start_s = ($urandom_range(0, 3) == 0);
            else start_s = ($urandom_range(0, 149) == 0);
            in_valid_s  = ($urandom_range(0, 9) < 7);
            mem_ready_s = ($urandom_range(0, 9) < 6);
            step();
            if (accepted || !in_valid_s) rand_beat($urandom_range(0, 9) == 0);
        end
        start_s = 1'b0;
        in_valid_s = 1'b0;
        mem_ready_s = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
